// File: rtl/usi_reg_fifo_map.sv
// usi_reg_fifo_map: USI register map with TX/RX FIFOs, sticky W1C ERROR and STATUS registers.
// Define USI_REGMAP_IRQ_EN to add the IRQ_EN register at 0x1C and the registered irq output.
`default_nettype none

module usi_reg_fifo_map #(
  parameter int                ADDR_W    = 32,
  parameter int                TX_DEPTH  = 8,
  parameter int                RX_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              bus_wen,
  input  logic              bus_ren,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_error,
  output logic [1:0]        mode_sel,
  output logic [31:0]       clkdiv,
  output logic [31:0]       parameters,
  output logic [31:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [31:0]       rx_data,
  input  logic              rx_valid,
  input  logic              ctrl_unit_error,
  output logic              irq
);
  localparam int         TXP      = $clog2(TX_DEPTH);
  localparam int         RXP      = $clog2(RX_DEPTH);
  localparam logic [8:0] ERR_MASK = 9'h10F;

  logic [ADDR_W-1:0] off;
  logic [7:0]        sel;  // one-hot: MODE, CLKDIV, PARAMS, TX, RX, STATUS, ERROR, IRQ_EN
  logic              mapped, wr, rd;

  logic [1:0]  mode_q;
  logic [31:0] clkdiv_q, params_q;
  logic [8:0]  err_q, err_d, err_set, err_clr;

  logic [31:0]  tx_mem [TX_DEPTH];
  logic [TXP-1:0] tx_wp_q, tx_rp_q;
  logic [TXP:0]   tx_cnt_q, tx_cnt_d;
  logic           tx_full, tx_pop, tx_push_req, tx_push, tx_ovf;

  logic [31:0]  rx_mem [RX_DEPTH];
  logic [RXP-1:0] rx_wp_q, rx_rp_q;
  logic [RXP:0]   rx_cnt_q, rx_cnt_d;
  logic           rx_full, rx_empty, rx_pop_req, rx_pop, rx_unf, rx_push, rx_ovf;
  logic [31:0]    rx_head, status;

  assign off = bus_addr - BASE_ADDR;

  always_comb begin
    sel = '0;
    if (off[ADDR_W-1:5] == '0) begin
      case (off[4:0])
        5'h00:   sel[0] = 1'b1;
        5'h04:   sel[1] = 1'b1;
        5'h08:   sel[2] = 1'b1;
        5'h0C:   sel[3] = 1'b1;
        5'h10:   sel[4] = 1'b1;
        5'h14:   sel[5] = 1'b1;
        5'h18:   sel[6] = 1'b1;
`ifdef USI_REGMAP_IRQ_EN
        5'h1C:   sel[7] = 1'b1;
`endif
        default: sel = '0;
      endcase
    end
  end

  assign mapped    = |sel;
  assign wr        = bus_wen & ~bus_ren;
  assign rd        = bus_ren & ~bus_wen;
  assign bus_error = (bus_wen | bus_ren) &
                     ((bus_wen & bus_ren) | ~mapped | (bus_wen & (sel[4] | sel[5])));

  // A full TX FIFO still accepts a bus push when the core pops in the same cycle.
  assign tx_full     = (tx_cnt_q == (TXP+1)'(TX_DEPTH));
  assign tx_valid    = (tx_cnt_q != '0);
  assign tx_data     = tx_valid ? tx_mem[tx_rp_q] : '0;
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = wr & sel[3];
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovf      = tx_push_req & ~tx_push;
  assign tx_cnt_d    = tx_cnt_q + {{TXP{1'b0}}, tx_push} - {{TXP{1'b0}}, tx_pop};

  assign rx_full    = (rx_cnt_q == (RXP+1)'(RX_DEPTH));
  assign rx_empty   = (rx_cnt_q == '0);
  assign rx_head    = rx_empty ? '0 : rx_mem[rx_rp_q];
  assign rx_pop_req = rd & sel[4];
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign rx_unf     = rx_pop_req & rx_empty;
  assign rx_push    = rx_valid & (~rx_full | rx_pop);
  assign rx_ovf     = rx_valid & ~rx_push;
  assign rx_cnt_d   = rx_cnt_q + {{RXP{1'b0}}, rx_push} - {{RXP{1'b0}}, rx_pop};

  assign status = {14'b0, rx_empty, tx_full, 8'(rx_cnt_q), 8'(tx_cnt_q)};

  // Set events are ORed in after the clear so a simultaneous set wins.
  assign err_set = {ctrl_unit_error, 4'b0, rx_unf, rx_ovf, tx_ovf, bus_error};
  assign err_clr = (wr & sel[6]) ? bus_wdata[8:0] : 9'b0;
  assign err_d   = ((err_q & ~err_clr) | err_set) & ERR_MASK;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q   <= '0;
      clkdiv_q <= '0;
      params_q <= '0;
      err_q    <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (wr & sel[0]) mode_q   <= bus_wdata[1:0];
      if (wr & sel[1]) clkdiv_q <= bus_wdata;
      if (wr & sel[2]) params_q <= bus_wdata;
      err_q <= err_d;
      if (tx_push) tx_wp_q <= tx_wp_q + TXP'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + TXP'(1);
      tx_cnt_q <= tx_cnt_d;
      if (rx_push) rx_wp_q <= rx_wp_q + RXP'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + RXP'(1);
      rx_cnt_q <= rx_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wp_q] <= bus_wdata;
    if (rx_push) rx_mem[rx_wp_q] <= rx_data;
  end

`ifdef USI_REGMAP_IRQ_EN
  logic [8:0] irqen_q;
  logic       irq_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      irqen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (wr & sel[7]) irqen_q <= bus_wdata[8:0] & ERR_MASK;
      irq_q <= |(err_q & irqen_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    bus_rdata = '0;
    if (rd) begin
      if (sel[0]) bus_rdata = {30'b0, mode_q};
      if (sel[1]) bus_rdata = clkdiv_q;
      if (sel[2]) bus_rdata = params_q;
      if (sel[4]) bus_rdata = rx_head;
      if (sel[5]) bus_rdata = status;
      if (sel[6]) bus_rdata = {23'b0, err_q};
`ifdef USI_REGMAP_IRQ_EN
      if (sel[7]) bus_rdata = {23'b0, irqen_q};
`endif
    end
  end

  assign mode_sel   = mode_q;
  assign clkdiv     = clkdiv_q;
  assign parameters = params_q;

endmodule

`default_nettype wire

// File: tb/tb_usi_reg_fifo_map.sv
// Scoreboard bench for usi_reg_fifo_map: a queue-based reference model predicts every bus
// response, TX handshake and irq value; a negedge monitor pops and compares them.
`default_nettype none

module tb_usi_reg_fifo_map;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        bus_wen = 1'b0, bus_ren = 1'b0;
  logic [31:0] bus_addr = '0, bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_error;
  logic [1:0]  mode_sel;
  logic [31:0] clkdiv, parameters, tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        ctrl_unit_error = 1'b0;
  logic        irq;

  always #5 CLK = ~CLK;

  usi_reg_fifo_map #(
    .ADDR_W(32), .TX_DEPTH(8), .RX_DEPTH(8), .BASE_ADDR(32'h0)
  ) dut (
    .CLK(CLK), .RST(RST), .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_error(bus_error),
    .mode_sel(mode_sel), .clkdiv(clkdiv), .parameters(parameters),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .ctrl_unit_error(ctrl_unit_error), .irq(irq)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [32:0] txh_q[$];
  logic        irq_q[$];

  // Reference model state
  logic [31:0] m_tx[$];
  logic [31:0] m_rx[$];
  logic [1:0]  m_mode;
  logic [31:0] m_clkdiv, m_params;
  logic [8:0]  m_err, m_irqen;
  logic        m_irq;
  localparam logic [8:0] EMASK = 9'h10F;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tx.delete(); m_rx.delete();
    m_mode = '0; m_clkdiv = '0; m_params = '0; m_err = '0; m_irqen = '0; m_irq = 1'b0;
    bus_q.delete(); txh_q.delete(); irq_q.delete();
  endtask

  function automatic bit is_mapped(input logic [31:0] off);
    case (off)
      32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18: return 1'b1;
`ifdef USI_REGMAP_IRQ_EN
      32'h1C: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // One bus clock: drive inputs, predict the visible responses, then advance the model.
  task automatic cycle(input logic wen, input logic ren, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic trdy, input logic rvld,
                       input logic [31:0] rdat, input logic cue);
    logic [31:0] rdv;
    logic        err, aw, ar, irq_n;
    logic [8:0]  set, clr;
    @(posedge CLK); #1;
    bus_wen = wen; bus_ren = ren; bus_addr = addr; bus_wdata = wdata;
    tx_ready = trdy; rx_valid = rvld; rx_data = rdat; ctrl_unit_error = cue;

    aw  = wen & ~ren;
    ar  = ren & ~wen;
    err = (wen | ren) && ((wen && ren) || !is_mapped(addr) ||
                          (wen && (addr == 32'h10 || addr == 32'h14)));
    rdv = '0;
    if (ar && is_mapped(addr)) begin
      case (addr)
        32'h00: rdv = {30'b0, m_mode};
        32'h04: rdv = m_clkdiv;
        32'h08: rdv = m_params;
        32'h10: rdv = (m_rx.size() > 0) ? m_rx[0] : 32'h0;
        32'h14: rdv = {14'b0, m_rx.size() == 0, m_tx.size() == 8,
                       8'(m_rx.size()), 8'(m_tx.size())};
        32'h18: rdv = {23'b0, m_err};
        32'h1C: rdv = {23'b0, m_irqen};
        default: rdv = '0;
      endcase
    end
    if (wen | ren) bus_q.push_back({rdv, err});
    if (trdy) txh_q.push_back((m_tx.size() > 0) ? {1'b1, m_tx[0]} : 33'h0);
    irq_q.push_back(m_irq);

    irq_n  = |(m_err & m_irqen);
    set    = '0;
    set[0] = err;
    set[8] = cue;
    if (trdy && m_tx.size() > 0) void'(m_tx.pop_front());
    if (aw && addr == 32'h0C) begin
      if (m_tx.size() < 8) m_tx.push_back(wdata); else set[1] = 1'b1;
    end
    if (ar && addr == 32'h10) begin
      if (m_rx.size() > 0) void'(m_rx.pop_front()); else set[3] = 1'b1;
    end
    if (rvld) begin
      if (m_rx.size() < 8) m_rx.push_back(rdat); else set[2] = 1'b1;
    end
    clr = (aw && addr == 32'h18) ? wdata[8:0] : 9'h0;
    if (aw) begin
      if (addr == 32'h00) m_mode   = wdata[1:0];
      if (addr == 32'h04) m_clkdiv = wdata;
      if (addr == 32'h08) m_params = wdata;
`ifdef USI_REGMAP_IRQ_EN
      if (addr == 32'h1C) m_irqen = wdata[8:0] & EMASK;
`endif
    end
    m_err = ((m_err & ~clr) | set) & EMASK;
    m_irq = irq_n;
  endtask

  task automatic idle();        cycle(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0); endtask
  task automatic bwr(input logic [31:0] a, input logic [31:0] d); cycle(1, 0, a, d, 0, 0, 32'h0, 0); endtask
  task automatic brd(input logic [31:0] a); cycle(0, 1, a, 32'h0, 0, 0, 32'h0, 0); endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (bus_wen | bus_ren) begin
        if (bus_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL bus_scoreboard: access with no expected entry at %0t", $time);
        end else begin
          bus_exp_t e;
          e = bus_q.pop_front();
          check("bus_rdata", 64'(bus_rdata), 64'(e.rdata));
          check("bus_error", 64'(bus_error), 64'(e.err));
        end
      end
      if (tx_ready && txh_q.size() > 0) begin
        logic [32:0] t;
        t = txh_q.pop_front();
        check("tx_valid", 64'(tx_valid), 64'(t[32]));
        if (t[32]) check("tx_data", 64'(tx_data), 64'(t[31:0]));
      end
      if (irq_q.size() > 0) check("irq", 64'(irq), 64'(irq_q.pop_front()));
    end
  end

  initial begin
    logic [31:0] addrs [11];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
              32'h20, 32'h03, 32'h40};
    model_reset();
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    check("reset_tx_valid", 64'(tx_valid), 64'h0);
    check("reset_irq", 64'(irq), 64'h0);
    check("reset_mode_sel", 64'(mode_sel), 64'h0);
    mon_en = 1'b1;

    brd(32'h00); brd(32'h04); brd(32'h14); brd(32'h18);

    // TX fill, overflow, drain
    for (int i = 1; i <= 9; i++) bwr(32'h0C, 32'(i));
    brd(32'h14); brd(32'h18);
    for (int i = 0; i < 9; i++) cycle(0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 0);
    bwr(32'h18, 32'h2); brd(32'h18);

    // RX push, reads including underflow, W1C
    cycle(0, 0, 32'h0, 32'h0, 0, 1, 32'hA5A5_0001, 0);
    cycle(0, 0, 32'h0, 32'h0, 0, 1, 32'h5A5A_0002, 0);
    brd(32'h10); brd(32'h10); brd(32'h10); brd(32'h18);
    bwr(32'h18, 32'h8); brd(32'h18);

    // RX full with simultaneous push and pop, then overflow
    for (int i = 0; i < 8; i++) cycle(0, 0, 32'h0, 32'h0, 0, 1, 32'h100 + 32'(i), 0);
    cycle(0, 1, 32'h10, 32'h0, 0, 1, 32'hCAFE_0000, 0);
    brd(32'h14); brd(32'h18);
    cycle(0, 0, 32'h0, 32'h0, 0, 1, 32'hDEAD_0000, 0);
    brd(32'h18); bwr(32'h18, 32'h1FF);

    // Unmapped access and set-wins against a W1C clear
    brd(32'h20); brd(32'h18);
    cycle(1, 1, 32'h18, 32'h1, 0, 0, 32'h0, 0);
    brd(32'h18);
    cycle(1, 0, 32'h18, 32'h100, 0, 0, 32'h0, 1);
    brd(32'h18); bwr(32'h18, 32'h1FF);
    bwr(32'h14, 32'h0); bwr(32'h10, 32'h0); brd(32'h1C); brd(32'h18);

    // Register writes and read-back
    bwr(32'h00, 32'hFFFF_FFFE); bwr(32'h04, 32'h1234_5678); bwr(32'h08, 32'h8765_4321);
    brd(32'h00); brd(32'h04); brd(32'h08); brd(32'h0C);

`ifdef USI_REGMAP_IRQ_EN
    bwr(32'h18, 32'h1FF);
    bwr(32'h1C, 32'h100); brd(32'h1C);
    cycle(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1);
    idle(); idle(); idle();
    bwr(32'h18, 32'h100);
    idle(); idle(); idle();
`endif

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, d;
      logic w, r;
      int k;
      k = $urandom_range(0, 99);
      a = addrs[$urandom_range(0, 10)];
      d = $urandom();
      if ($urandom_range(0, 7) == 0) d = 32'h1FF;
      w = (k < 35) || (k >= 95);
      r = (k >= 35 && k < 70) || (k >= 95);
      if (w && !r && $urandom_range(0, 1) == 1) a = 32'h0C;
      cycle(w, r, a, d, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom(), $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 3; i++) bwr(32'h0C, 32'h77 + 32'(i));
    cycle(0, 0, 32'h0, 32'h0, 0, 1, 32'h55, 1);
    #2 RST = 1'b1;
    mon_en = 1'b0;
    bus_wen = 0; bus_ren = 0; tx_ready = 0; rx_valid = 0; ctrl_unit_error = 0;
    #1;
    check("async_reset_tx_valid", 64'(tx_valid), 64'h0);
    check("async_reset_irq", 64'(irq), 64'h0);
    model_reset();
    @(posedge CLK); #1 RST = 1'b0;
    mon_en = 1'b1;
    brd(32'h14); brd(32'h18); brd(32'h10); brd(32'h18);
    idle();
    @(negedge CLK);
    #1;
    check("scoreboard_drain", 64'(bus_q.size() + txh_q.size() + irq_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
